// File: rtl/rr_arbiter_2d_if.sv
// rr_arbiter_2d_if: request matrix and one-hot/binary grant handshake bundle for rr_arbiter_2d.
interface rr_arbiter_2d_if #(
  parameter int SEL_X_NUM = 32,
  parameter int SEL_Y_NUM = 16
);
  localparam int IDX_X_W = SEL_X_NUM > 1 ? $clog2(SEL_X_NUM) : 1;
  localparam int IDX_Y_W = SEL_Y_NUM > 1 ? $clog2(SEL_Y_NUM) : 1;
  logic [SEL_Y_NUM-1:0][SEL_X_NUM-1:0] req;
  logic                                gnt_valid;
  logic                                gnt_ready;
  logic [SEL_X_NUM-1:0]                gnt_x;
  logic [SEL_Y_NUM-1:0]                gnt_y;
  logic [IDX_X_W-1:0]                  gnt_idx_x;
  logic [IDX_Y_W-1:0]                  gnt_idx_y;
  modport master (
    input  req, gnt_ready,
    output gnt_valid, gnt_x, gnt_y, gnt_idx_x, gnt_idx_y
  );
  modport slave (
    output req, gnt_ready,
    input  gnt_valid, gnt_x, gnt_y, gnt_idx_x, gnt_idx_y
  );
endinterface

// File: rtl/rr_arbiter_2d.sv
// rr_arbiter_2d: two-level round-robin arbiter (row pointer + per-row column pointers) with registered one-hot grants.
module rr_arbiter_2d #(
  parameter int SEL_X_NUM = 32,
  parameter int SEL_Y_NUM = 16
) (
  input  logic            clk,
  input  logic            rstn,
  rr_arbiter_2d_if.master bus
);
  localparam int IDX_X_W = SEL_X_NUM > 1 ? $clog2(SEL_X_NUM) : 1;
  localparam int IDX_Y_W = SEL_Y_NUM > 1 ? $clog2(SEL_Y_NUM) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t                              state, state_nxt;
  logic [IDX_Y_W-1:0]                  row_ptr, row_ptr_n, win_y;
  logic [SEL_Y_NUM-1:0][IDX_X_W-1:0]   col_ptr, col_ptr_n;
  logic [SEL_Y_NUM-1:0][SEL_X_NUM-1:0] req_m;
  logic [IDX_X_W-1:0]                  win_x, idx_x_nxt;
  logic [IDX_Y_W-1:0]                  idx_y_nxt;
  logic [SEL_X_NUM-1:0]                x_nxt;
  logic [SEL_Y_NUM-1:0]                y_nxt;
  logic                                hs, arb, any, found_y, found_x;
  int                                  r, c;
  assign hs  = state == GRANT && bus.gnt_ready;
  assign arb = state == IDLE || bus.gnt_ready;
  assign bus.gnt_valid = state == GRANT;
  // On a handshake the winner is picked with the accepted bit masked and the advanced pointers.
  always_comb begin
    req_m     = bus.req;
    row_ptr_n = row_ptr;
    col_ptr_n = col_ptr;
    if (hs) begin
      req_m[bus.gnt_idx_y][bus.gnt_idx_x] = 1'b0;
      row_ptr_n = bus.gnt_idx_y == IDX_Y_W'(SEL_Y_NUM - 1) ? '0 : bus.gnt_idx_y + 1'b1;
      col_ptr_n[bus.gnt_idx_y] = bus.gnt_idx_x == IDX_X_W'(SEL_X_NUM - 1) ? '0 : bus.gnt_idx_x + 1'b1;
    end
    any     = |req_m;
    win_y   = '0;
    found_y = 1'b0;
    r       = 0;
    for (int i = 0; i < SEL_Y_NUM; i++) begin
      r = int'(row_ptr_n) + i;
      r = r >= SEL_Y_NUM ? r - SEL_Y_NUM : r;
      if (!found_y && |req_m[r]) begin
        found_y = 1'b1;
        win_y   = IDX_Y_W'(r);
      end
    end
    win_x   = '0;
    found_x = 1'b0;
    c       = 0;
    for (int j = 0; j < SEL_X_NUM; j++) begin
      c = int'(col_ptr_n[win_y]) + j;
      c = c >= SEL_X_NUM ? c - SEL_X_NUM : c;
      if (!found_x && req_m[win_y][c]) begin
        found_x = 1'b1;
        win_x   = IDX_X_W'(c);
      end
    end
  end
  always_comb begin
    state_nxt = arb ? (any ? GRANT : IDLE) : state;
  end
  // Grant outputs are held while stalled and cleared when arbitration finds nothing.
  always_comb begin
    x_nxt     = arb ? (any ? SEL_X_NUM'(1) << win_x : '0) : bus.gnt_x;
    y_nxt     = arb ? (any ? SEL_Y_NUM'(1) << win_y : '0) : bus.gnt_y;
    idx_x_nxt = arb ? win_x : bus.gnt_idx_x;
    idx_y_nxt = arb ? win_y : bus.gnt_idx_y;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      row_ptr       <= '0;
      col_ptr       <= '0;
      bus.gnt_x     <= '0;
      bus.gnt_y     <= '0;
      bus.gnt_idx_x <= '0;
      bus.gnt_idx_y <= '0;
    end else begin
      state         <= state_nxt;
      row_ptr       <= row_ptr_n;
      col_ptr       <= col_ptr_n;
      bus.gnt_x     <= x_nxt;
      bus.gnt_y     <= y_nxt;
      bus.gnt_idx_x <= idx_x_nxt;
      bus.gnt_idx_y <= idx_y_nxt;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_2d.sv
// tb_rr_arbiter_2d: directed and random checks of rr_arbiter_2d against a round-robin reference model.
module tb_rr_arbiter_2d;
  localparam int X = 4;
  localparam int Y = 2;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  rr_arbiter_2d_if #(.SEL_X_NUM(X), .SEL_Y_NUM(Y)) bus ();
  rr_arbiter_2d #(.SEL_X_NUM(X), .SEL_Y_NUM(Y)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  bit mv;
  int my, mx, rp;
  int cp[Y];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference: what the arbiter should hold after the coming edge, from the current inputs.
  task automatic model();
    logic [Y-1:0][X-1:0] m;
    bit f;
    if (!rstn) begin
      mv = 0; my = 0; mx = 0; rp = 0;
      foreach (cp[i]) cp[i] = 0;
      return;
    end
    if (mv && !bus.gnt_ready) return;
    m = bus.req;
    if (mv) begin
      m[my][mx] = 1'b0;
      rp = (my + 1) % Y;
      cp[my] = (mx + 1) % X;
    end
    f = 0;
    for (int i = 0; i < Y && !f; i++) begin
      int y = (rp + i) % Y;
      for (int k = 0; k < X && !f; k++) begin
        int x = (cp[y] + k) % X;
        if (m[y][x]) begin f = 1; my = y; mx = x; end
      end
    end
    mv = f;
    if (!f) begin my = 0; mx = 0; end
  endtask
  task automatic tick(input string tag);
    model();
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(mv));
    chk({tag, ".gnt_y"}, 32'(bus.gnt_y), mv ? 32'(1) << my : 32'd0);
    chk({tag, ".gnt_x"}, 32'(bus.gnt_x), mv ? 32'(1) << mx : 32'd0);
    chk({tag, ".idx_y"}, 32'(bus.gnt_idx_y), 32'(my));
    chk({tag, ".idx_x"}, 32'(bus.gnt_idx_x), 32'(mx));
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    tick("rst");
    rstn = 1'b1;
  endtask
  int ey3[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int ex3[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  logic [X-1:0] alt;
  initial begin
    bus.req = '1;
    bus.gnt_ready = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("t1");
      chk("t1.valid0", 32'(bus.gnt_valid), 32'd0);
      chk("t1.x0", 32'(bus.gnt_x), 32'd0);
    end
    rstn = 1'b1;
    bus.req = '0;
    bus.req[1][2] = 1'b1;
    tick("t2");
    chk("t2.gnt_y", 32'(bus.gnt_y), 32'b10);
    chk("t2.gnt_x", 32'(bus.gnt_x), 32'b0100);
    chk("t2.idx", {bus.gnt_idx_y, bus.gnt_idx_x}, 32'h6);
    bus.gnt_ready = 1'b1;
    bus.req = '0;
    tick("t2b");
    chk("t2b.valid0", 32'(bus.gnt_valid), 32'd0);
    do_reset();
    bus.req = '1;
    bus.gnt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick("t3");
      chk("t3.seq_y", 32'(bus.gnt_idx_y), 32'(ey3[k]));
      chk("t3.seq_x", 32'(bus.gnt_idx_x), 32'(ex3[k]));
    end
    bus.gnt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.req = 8'($urandom);
      tick("t4");
      chk("t4.hold", {bus.gnt_valid, bus.gnt_y, bus.gnt_x}, {1'b1, 2'b01, 4'b0001});
    end
    bus.req = '1;
    bus.gnt_ready = 1'b1;
    tick("t4b");
    chk("t4b.next", {bus.gnt_idx_y, bus.gnt_idx_x}, 32'h4);
    do_reset();
    bus.req = '0;
    bus.req[0][1] = 1'b1;
    bus.req[0][3] = 1'b1;
    alt = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick("t5");
      chk("t5.alt_x", 32'(bus.gnt_x), 32'(alt));
      chk("t5.y", 32'(bus.gnt_y), 32'b01);
      alt = alt == 4'b0010 ? 4'b1000 : 4'b0010;
    end
    do_reset();
    bus.req = '0;
    bus.req[1][3] = 1'b1;
    bus.gnt_ready = 1'b0;
    tick("t6a");
    chk("t6a.idx", {bus.gnt_idx_y, bus.gnt_idx_x}, 32'h7);
    tick("t6b");
    rstn = 1'b0;
    tick("t6r");
    chk("t6r.valid0", 32'(bus.gnt_valid), 32'd0);
    rstn = 1'b1;
    bus.req = '1;
    bus.gnt_ready = 1'b1;
    tick("t6c");
    chk("t6c.first", {bus.gnt_valid, bus.gnt_y, bus.gnt_x}, {1'b1, 2'b01, 4'b0001});
    for (int k = 0; k < 400; k++) begin
      bus.req = 8'($urandom);
      bus.gnt_ready = $urandom_range(0, 3) != 0;
      rstn = $urandom_range(0, 99) != 0;
      tick("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
